// File: rtl/dispatch_buffer_if.sv
// Rename-to-issue bus for dispatch_buffer: group input handshake, issue-queue
// backpressure, wake snoop inputs and the issue-queue write bus.
interface dispatch_buffer_if #(
    parameter int WRITE_NUM   = 2,
    parameter int REQ_W       = 89,
    parameter int IQ_NUM      = 3,
    parameter int WAKE_NUM    = 4,
    parameter int WAKE_W      = 7,
    parameter int ISSUE_WIDTH = 2
);
    logic                             in_valid;
    logic [WRITE_NUM-1:0][REQ_W-1:0]  in_group;
    logic                             in_ready;
    logic [IQ_NUM-1:0]                iq_full;
    logic [WAKE_NUM-1:0][WAKE_W-1:0]  wake;
    logic [ISSUE_WIDTH-1:0][31:0]     broadcast;
    logic [WRITE_NUM-1:0][REQ_W-1:0]  out_write;
    logic                             empty;

    modport master (
        output in_valid, in_group, iq_full, wake, broadcast,
        input  in_ready, out_write, empty
    );

    modport slave (
        input  in_valid, in_group, iq_full, wake, broadcast,
        output in_ready, out_write, empty
    );
endinterface

// File: rtl/dispatch_buffer.sv
// Dispatch buffer: FIFO of renamed groups between rename and the issue queues,
// with wake snooping. Define DISPATCH_BYPASS_EN for zero-latency pass-through.
module dispatch_buffer #(
    parameter int DEPTH  = 4,
    parameter int IQ_NUM = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    dispatch_buffer_if.slave bus
);
    localparam int WRITE_NUM   = 2;
    localparam int WAKE_NUM    = 4;
    localparam int ISSUE_WIDTH = 2;
    localparam int TYPE_W      = 2;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(DEPTH + 1);

    typedef enum logic [TYPE_W-1:0] {
        ET_ALU = 2'd0,
        ET_MEM = 2'd1,
        ET_BRU = 2'd2
    } entry_type_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  id;
        logic [31:0] data;
    } src_t;

    typedef struct packed {
        logic        valid;
        entry_type_t entry_type;
        logic [7:0]  op;
        src_t        src1;
        src_t        src2;
    } write_req_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] id;
    } wake_req_t;

    typedef write_req_t [WRITE_NUM-1:0] group_t;

    // Highest matching wake index wins; only the first ISSUE_WIDTH wakes carry data.
    function automatic src_t wake_src(src_t s, wake_req_t [WAKE_NUM-1:0] w,
                                      logic [WAKE_NUM-1:0][31:0] bc);
        src_t        r;
        logic        hit;
        logic        has_data;
        logic [31:0] d;
        r        = s;
        hit      = 1'b0;
        has_data = 1'b0;
        d        = s.data;
        for (int i = 0; i < WAKE_NUM; i++) begin
            if (w[i].valid && (w[i].id == s.id)) begin
                hit = 1'b1;
                if (i < ISSUE_WIDTH) begin
                    has_data = 1'b1;
                    d        = bc[i];
                end else begin
                    has_data = 1'b0;
                end
            end
        end
        if (hit)      r.valid = 1'b1;
        if (has_data) r.data  = d;
        return r;
    endfunction

    function automatic group_t wake_group(group_t g, wake_req_t [WAKE_NUM-1:0] w,
                                          logic [WAKE_NUM-1:0][31:0] bc);
        group_t r;
        r = g;
        for (int k = 0; k < WRITE_NUM; k++) begin
            r[k].src1 = wake_src(g[k].src1, w, bc);
            r[k].src2 = wake_src(g[k].src2, w, bc);
        end
        return r;
    endfunction

    function automatic logic group_eligible(group_t g, logic [2**TYPE_W-1:0] full);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < WRITE_NUM; k++) begin
            if (g[k].valid && full[g[k].entry_type]) ok = 1'b0;
        end
        return ok;
    endfunction

    group_t                    mem_q [DEPTH];
    group_t                    woken [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;

    wake_req_t [WAKE_NUM-1:0]  wake_in;
    logic [WAKE_NUM-1:0][31:0] bc_ext;
    logic [2**TYPE_W-1:0]      full_ext;
    group_t                    in_woken;
    group_t                    head_grp;
    logic                      head_ok;
    logic                      bypass;
    logic                      in_ready_int;
    logic                      push;
    logic                      pop;

    always_comb begin
        wake_in                    = bus.wake;
        bc_ext                     = '0;
        bc_ext[ISSUE_WIDTH-1:0]    = bus.broadcast;
        full_ext                   = '0;
        full_ext[IQ_NUM-1:0]       = bus.iq_full;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign woken[gi] = wake_group(mem_q[gi], wake_in, bc_ext);
        end
    endgenerate

    assign in_woken     = wake_group(bus.in_group, wake_in, bc_ext);
    assign head_grp     = woken[head_q];
    assign head_ok      = (count_q != '0) && group_eligible(head_grp, full_ext);
    assign in_ready_int = (count_q != CNT_W'(DEPTH));

`ifdef DISPATCH_BYPASS_EN
    assign bypass = (count_q == '0) && bus.in_valid && group_eligible(in_woken, full_ext);
`else
    assign bypass = 1'b0;
`endif

    assign pop  = head_ok;
    assign push = bus.in_valid && in_ready_int && !bypass;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + 1'b1;
        if (push) tail_d = tail_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        bus.out_write = '0;
        if (head_ok)     bus.out_write = head_grp;
        else if (bypass) bus.out_write = in_woken;
    end

    assign bus.in_ready = in_ready_int;
    assign bus.empty    = (count_q == '0);

    // Every stored entry is rewritten each cycle so snooped wakes are never lost.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= woken[e];
            if (push) mem_q[tail_q] <= in_woken;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_dispatch_buffer;
    localparam int DEPTH       = 4;
    localparam int IQ_NUM      = 3;
    localparam int WRITE_NUM   = 2;
    localparam int WAKE_NUM    = 4;
    localparam int ISSUE_WIDTH = 2;

    typedef struct packed {
        logic        valid;
        logic [5:0]  id;
        logic [31:0] data;
    } src_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  entry_type;
        logic [7:0]  op;
        src_t        src1;
        src_t        src2;
    } write_req_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] id;
    } wake_req_t;

    typedef write_req_t [WRITE_NUM-1:0] group_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    dispatch_buffer_if bus ();

    dispatch_buffer #(.DEPTH(DEPTH), .IQ_NUM(IQ_NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int     n_tests  = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     checking = 0;
    group_t model_q[$];

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference wake: scan from the highest index down, first hit decides.
    function automatic src_t m_wake_src(src_t s, wake_req_t [WAKE_NUM-1:0] w,
                                        logic [ISSUE_WIDTH-1:0][31:0] bc);
        for (int i = WAKE_NUM - 1; i >= 0; i--) begin
            if (w[i].valid && w[i].id == s.id) begin
                s.valid = 1'b1;
                if (i < ISSUE_WIDTH) s.data = bc[i];
                return s;
            end
        end
        return s;
    endfunction

    function automatic group_t m_wake(group_t g, wake_req_t [WAKE_NUM-1:0] w,
                                      logic [ISSUE_WIDTH-1:0][31:0] bc);
        for (int k = 0; k < WRITE_NUM; k++) begin
            g[k].src1 = m_wake_src(g[k].src1, w, bc);
            g[k].src2 = m_wake_src(g[k].src2, w, bc);
        end
        return g;
    endfunction

    function automatic bit m_elig(group_t g, logic [IQ_NUM-1:0] full);
        for (int k = 0; k < WRITE_NUM; k++)
            if (g[k].valid && full[g[k].entry_type]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic group_t mask(group_t g);
        for (int k = 0; k < WRITE_NUM; k++)
            if (!g[k].valid) g[k] = '0;
        return g;
    endfunction

    function automatic group_t mk(int t0, bit v0, int t1, bit v1, int op);
        group_t g;
        g = '0;
        g[0].valid = v0; g[0].entry_type = 2'(t0); g[0].op = 8'(op);
        g[1].valid = v1; g[1].entry_type = 2'(t1); g[1].op = 8'(op + 128);
        g[0].src1.id = 6'd60; g[0].src2.id = 6'd61;
        g[1].src1.id = 6'd62; g[1].src2.id = 6'd63;
        return g;
    endfunction

    function automatic group_t rand_grp();
        group_t g;
        for (int k = 0; k < WRITE_NUM; k++) begin
            g[k].valid      = ($urandom_range(3) != 0);
            g[k].entry_type = 2'($urandom_range(2));
            g[k].op         = 8'($urandom);
            g[k].src1.valid = 1'($urandom);
            g[k].src1.id    = 6'($urandom_range(7));
            g[k].src1.data  = $urandom;
            g[k].src2.valid = 1'($urandom);
            g[k].src2.id    = 6'($urandom_range(7));
            g[k].src2.data  = $urandom;
        end
        return g;
    endfunction

    task automatic set_idle();
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_group  = '0;
        bus.wake      = '0;
        bus.broadcast = '0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic tick();
        group_t woken_q[$];
        group_t inw, exp_out, got;
        bit     pop, push, byp;
        int     n;
        @(negedge clk);
        woken_q = {};
        foreach (model_q[j]) woken_q.push_back(m_wake(model_q[j], bus.wake, bus.broadcast));
        inw = m_wake(bus.in_group, bus.wake, bus.broadcast);
        n   = model_q.size();
        pop = (n > 0) && m_elig(woken_q[0], bus.iq_full);
        byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
        byp = (n == 0) && bus.in_valid && m_elig(inw, bus.iq_full);
`endif
        push    = bus.in_valid && (n < DEPTH) && !byp;
        exp_out = '0;
        if (pop)      exp_out = woken_q[0];
        else if (byp) exp_out = inw;
        if (checking) begin
            check("in_ready", 256'(bus.in_ready), 256'(n != DEPTH));
            check("empty", 256'(bus.empty), 256'(n == 0));
            if (!reset && !flush) begin
                got = bus.out_write;
                check("out_write", 256'(mask(got)), 256'(mask(exp_out)));
            end
        end
        @(posedge clk);
        if (reset || flush) begin
            model_q = {};
        end else begin
            model_q = woken_q;
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(inw);
        end
        if (push || pop || byp || reset || flush)
            $display("[TB] cyc %0d rst=%0b flush=%0b push=%0b pop=%0b bypass=%0b occ=%0d",
                     cyc, reset, flush, push, pop, byp, model_q.size());
        cyc++;
        #1;
        if (reset) checking = 1'b1;
    endtask

    initial begin : stim
        group_t          g;
        wake_req_t [3:0] w;
        set_idle();
        bus.iq_full = '0;
        reset       = 1'b1;
        tick();
        tick();

        // Single ALU group through an empty buffer
        set_idle();
        bus.in_valid = 1'b1;
        bus.in_group = mk(0, 1, 0, 0, 1);
        tick();
        set_idle();
        #1;
        g = bus.out_write;
`ifdef DISPATCH_BYPASS_EN
        check("first_group_visible", 256'(g[0].valid), 256'(0));
`else
        check("first_group_visible", 256'(g[0].valid), 256'(1));
`endif
        tick();
        #1;
        check("empty_after_pop", 256'(bus.empty), 256'(1));

        // Fill while all queues are full, fifth push refused, drain across the wrap
        bus.iq_full = 3'b111;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_group = mk(0, 1, 1, 0, 16 + i);
            tick();
        end
        set_idle();
        #1;
        check("fill_in_ready", 256'(bus.in_ready), 256'(0));
        bus.iq_full = 3'b000;
        #1;
        g = bus.out_write;
        check("drain_first_op", 256'(g[0].op), 256'(16));
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("drained_empty", 256'(bus.empty), 256'(1));

        // Partial stall: MEM queue full blocks the whole group
        bus.iq_full  = 3'b010;
        bus.in_valid = 1'b1;
        bus.in_group = mk(0, 1, 1, 1, 32);
        tick();
        set_idle();
        #1;
        g = bus.out_write;
        check("stall_hold", 256'({g[1].valid, g[0].valid}), 256'(2'b00));
        tick();
        tick();
        bus.iq_full = 3'b000;
        #1;
        g = bus.out_write;
        check("stall_release", 256'({g[1].valid, g[0].valid}), 256'(2'b11));
        tick();

        // Wake of a stored entry
        bus.iq_full  = 3'b001;
        g            = mk(0, 1, 2, 0, 48);
        g[0].src1.id = 6'd7;
        bus.in_valid = 1'b1;
        bus.in_group = g;
        tick();
        set_idle();
        w = '0; w[0].valid = 1'b1; w[0].id = 6'd7;
        bus.wake      = w;
        bus.broadcast = {32'h0, 32'hDEAD_BEEF};
        tick();
        set_idle();
        bus.iq_full = 3'b000;
        #1;
        g = bus.out_write;
        check("wake_stored_valid", 256'(g[0].src1.valid), 256'(1));
        check("wake_stored_data", 256'(g[0].src1.data), 256'(32'hDEAD_BEEF));
        tick();

        // Wake of in_group during its push cycle
        bus.iq_full  = 3'b001;
        g            = mk(0, 1, 2, 0, 49);
        g[0].src1.id = 6'd7;
        bus.in_valid  = 1'b1;
        bus.in_group  = g;
        bus.wake      = w;
        bus.broadcast = {32'h0, 32'hDEAD_BEEF};
        tick();
        set_idle();
        bus.iq_full = 3'b000;
        #1;
        g = bus.out_write;
        check("wake_push_data", 256'({g[0].src1.valid, g[0].src1.data}), 256'({1'b1, 32'hDEAD_BEEF}));
        tick();

        // Flush with a simultaneous push
        bus.iq_full = 3'b111;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_group = mk(0, 1, 1, 1, 64 + i);
            tick();
        end
        flush = 1'b1;
        bus.in_group = mk(0, 1, 1, 1, 70);
        tick();
        set_idle();
        #1;
        check("flush_empty", 256'(bus.empty), 256'(1));
        check("flush_in_ready", 256'(bus.in_ready), 256'(1));
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(99) == 0);
            flush         = ($urandom_range(99) < 3);
            bus.in_valid  = ($urandom_range(9) < 6);
            bus.in_group  = rand_grp();
            bus.iq_full   = {($urandom_range(9) < 3), ($urandom_range(9) < 3), ($urandom_range(9) < 3)};
            for (int i = 0; i < WAKE_NUM; i++) begin
                w[i].valid = 1'($urandom);
                w[i].id    = 6'($urandom_range(7));
            end
            bus.wake      = w;
            bus.broadcast = {$urandom, $urandom};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
